czonotope_loader: RTL and testbench

Stream-to-memory loader for constrained zonotopes. It accepts one frame of 32-bit words on a valid/ready stream: a dimension header, then center, generator matrix, constraint matrix and constraint vector. It writes each element into the Z center/G/A/b memories that the CZonotope operators read, and publishes the dimensions on the Zn/Zng/Znc buses. It is the write side of those memories and is instantiated ahead of the linear-image and other CZonotope operators.

---
 rtl/czonotope_loader.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_czonotope_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/czonotope_loader.sv
`default_nettype none
// ============================================================================
//  Module      : czonotope_loader
//  Description : Stream-to-memory loader for constrained zonotopes. Parses a
//                dimension header, then scatters center, G, A and b words into
//                the Z memories through registered write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module czonotope_loader #(
    parameter int NMAX       = 3,
    parameter int NGMAX      = 15,
    parameter int NCMAX      = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [DATA_WIDTH-1:0]      s_data_i,
    input  logic                       s_last_i,
    output logic [$clog2(NMAX)-1:0]    Zn,
    output logic [$clog2(NGMAX)-1:0]   Zng,
    output logic [$clog2(NCMAX)-1:0]   Znc,
    output logic                       Zc_we,
    output logic [$clog2(NMAX)-1:0]    Zc_addr,
    output logic [DATA_WIDTH-1:0]      Zc_wdata,
    output logic                       ZG_we,
    output logic [$clog2(NMAX)-1:0]    ZG_raddr,
    output logic [$clog2(NGMAX)-1:0]   ZG_caddr,
    output logic [DATA_WIDTH-1:0]      ZG_wdata,
    output logic                       ZA_we,
    output logic [$clog2(NCMAX)-1:0]   ZA_raddr,
    output logic [$clog2(NGMAX)-1:0]   ZA_caddr,
    output logic [DATA_WIDTH-1:0]      ZA_wdata,
    output logic                       Zb_we,
    output logic [$clog2(NCMAX)-1:0]   Zb_addr,
    output logic [DATA_WIDTH-1:0]      Zb_wdata,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int c_NW = $clog2(NMAX);
    localparam int c_GW = $clog2(NGMAX);
    localparam int c_CW = $clog2(NCMAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_C  = 3'd1,
        S_LD_G  = 3'd2,
        S_LD_A  = 3'd3,
        S_LD_B  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    state_t                w_next_phase;
    logic                  r_ready;
    logic [7:0]            r_row;
    logic [7:0]            r_col;
    logic [7:0]            w_row_nx;
    logic [7:0]            w_col_nx;
    logic [c_NW-1:0]       r_zn;
    logic [c_GW-1:0]       r_zng;
    logic [c_CW-1:0]       r_znc;
    logic                  r_zc_we;
    logic                  r_zg_we;
    logic                  r_za_we;
    logic                  r_zb_we;
    logic [7:0]            r_wrow;
    logic [7:0]            r_wcol;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_done;
    logic                  r_err;

    logic                  w_acc;
    logic [7:0]            w_hn;
    logic [7:0]            w_hng;
    logic [7:0]            w_hnc;
    logic                  w_hdr_ok;
    logic [7:0]            w_n8;
    logic [7:0]            w_ng8;
    logic [7:0]            w_nc8;
    logic                  w_col_last;
    logic                  w_phase_end;
    logic                  w_frame_end;
    logic                  w_we_c;
    logic                  w_we_g;
    logic                  w_we_a;
    logic                  w_we_b;
    logic                  w_done;
    logic                  w_err_set;
    logic                  w_err_clr;
    logic                  w_ld_dims;

    assign w_acc    = s_valid_i && r_ready;
    assign w_hn     = s_data_i[7:0];
    assign w_hng    = s_data_i[15:8];
    assign w_hnc    = s_data_i[23:16];
    assign w_hdr_ok = (w_hn != 8'd0) && (int'(w_hn) <= NMAX) &&
                      (int'(w_hng) <= NGMAX) && (int'(w_hnc) <= NCMAX);
    assign w_n8     = 8'(r_zn);
    assign w_ng8    = 8'(r_zng);
    assign w_nc8    = 8'(r_znc);

    // Next-state, counter advance and write-strobe decode for one accepted word
    always_comb begin
        w_state_nx   = r_state;
        w_next_phase = S_IDLE;
        w_row_nx     = r_row;
        w_col_nx     = r_col;
        w_phase_end  = 1'b0;
        w_we_c       = 1'b0;
        w_we_g       = 1'b0;
        w_we_a       = 1'b0;
        w_we_b       = 1'b0;
        w_done       = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        w_ld_dims    = 1'b0;
        // ng is non-zero whenever a matrix phase is active, so the wrap of ng-1 is harmless
        w_col_last   = (r_col == w_ng8 - 8'd1);

        // Phase boundaries; empty phases are skipped when choosing the successor
        case (r_state)
            S_LD_C: begin
                w_phase_end  = (r_row == w_n8 - 8'd1);
                w_next_phase = (w_ng8 != 8'd0) ? S_LD_G :
                               (w_nc8 != 8'd0) ? S_LD_B : S_IDLE;
            end
            S_LD_G: begin
                w_phase_end  = (r_row == w_n8 - 8'd1) && w_col_last;
                w_next_phase = (w_nc8 != 8'd0) ? S_LD_A : S_IDLE;
            end
            S_LD_A: begin
                w_phase_end  = (r_row == w_nc8 - 8'd1) && w_col_last;
                w_next_phase = S_LD_B;
            end
            S_LD_B: begin
                w_phase_end  = (r_row == w_nc8 - 8'd1);
                w_next_phase = S_IDLE;
            end
            default: begin
                w_phase_end  = 1'b0;
                w_next_phase = S_IDLE;
            end
        endcase
        w_frame_end = w_phase_end && (w_next_phase == S_IDLE);

        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (w_hdr_ok) begin
                        w_ld_dims = 1'b1;
                        w_err_clr = 1'b1;
                        w_row_nx  = 8'd0;
                        w_col_nx  = 8'd0;
                        if (!s_last_i) begin
                            w_state_nx = S_LD_C;
                        end
                    end else begin
                        w_err_set = 1'b1;
                        if (!s_last_i) begin
                            w_state_nx = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (s_last_i) begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    if (s_last_i && !w_frame_end) begin
                        // Premature end of frame: drop this word and abandon the frame
                        w_err_set  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_we_c = (r_state == S_LD_C);
                        w_we_g = (r_state == S_LD_G);
                        w_we_a = (r_state == S_LD_A);
                        w_we_b = (r_state == S_LD_B);
                        if (w_phase_end) begin
                            w_row_nx   = 8'd0;
                            w_col_nx   = 8'd0;
                            w_state_nx = w_next_phase;
                            if (w_frame_end) begin
                                w_done = 1'b1;
                                // A missing end marker still completes the write but flags the frame
                                if (!s_last_i) begin
                                    w_err_set  = 1'b1;
                                    w_state_nx = S_DRAIN;
                                end
                            end
                        end else if ((r_state == S_LD_C) || (r_state == S_LD_B)) begin
                            w_row_nx = r_row + 8'd1;
                        end else if (w_col_last) begin
                            w_col_nx = 8'd0;
                            w_row_nx = r_row + 8'd1;
                        end else begin
                            w_col_nx = r_col + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // State, counters, dimension latches and registered write ports
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_row   <= 8'd0;
            r_col   <= 8'd0;
            r_zn    <= '0;
            r_zng   <= '0;
            r_znc   <= '0;
            r_zc_we <= 1'b0;
            r_zg_we <= 1'b0;
            r_za_we <= 1'b0;
            r_zb_we <= 1'b0;
            r_wrow  <= 8'd0;
            r_wcol  <= 8'd0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ready <= 1'b1;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_zc_we <= w_we_c;
            r_zg_we <= w_we_g;
            r_za_we <= w_we_a;
            r_zb_we <= w_we_b;
            r_done  <= w_done;
            if (w_ld_dims) begin
                r_zn  <= w_hn[c_NW-1:0];
                r_zng <= w_hng[c_GW-1:0];
                r_znc <= w_hnc[c_CW-1:0];
            end
            if (w_we_c || w_we_g || w_we_a || w_we_b) begin
                r_wrow  <= r_row;
                r_wcol  <= r_col;
                r_wdata <= s_data_i;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign s_ready_o = r_ready;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign Zn        = r_zn;
    assign Zng       = r_zng;
    assign Znc       = r_znc;

    assign Zc_we     = r_zc_we;
    assign Zc_addr   = r_wrow[c_NW-1:0];
    assign Zc_wdata  = r_wdata;
    assign ZG_we     = r_zg_we;
    assign ZG_raddr  = r_wrow[c_NW-1:0];
    assign ZG_caddr  = r_wcol[c_GW-1:0];
    assign ZG_wdata  = r_wdata;
    assign ZA_we     = r_za_we;
    assign ZA_raddr  = r_wrow[c_CW-1:0];
    assign ZA_caddr  = r_wcol[c_GW-1:0];
    assign ZA_wdata  = r_wdata;
    assign Zb_we     = r_zb_we;
    assign Zb_addr   = r_wrow[c_CW-1:0];
    assign Zb_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_czonotope_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_czonotope_loader
//  Description : Directed self-checking bench for czonotope_loader. A write
//                monitor logs every strobe; logs are compared against
//                expected write lists generated from frame dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_czonotope_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  Zn;
    logic [3:0]  Zng;
    logic [3:0]  Znc;
    logic        Zc_we;
    logic [1:0]  Zc_addr;
    logic [31:0] Zc_wdata;
    logic        ZG_we;
    logic [1:0]  ZG_raddr;
    logic [3:0]  ZG_caddr;
    logic [31:0] ZG_wdata;
    logic        ZA_we;
    logic [3:0]  ZA_raddr;
    logic [3:0]  ZA_caddr;
    logic [31:0] ZA_wdata;
    logic        Zb_we;
    logic [3:0]  Zb_addr;
    logic [31:0] Zb_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          dcnt   = 0;
    int          multi  = 0;
    int          nwe;
    logic [63:0] log_q[$];
    logic [63:0] exp_q[$];

    czonotope_loader #(
        .NMAX(3), .NGMAX(15), .NCMAX(12), .DATA_WIDTH(32)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .Zn(Zn), .Zng(Zng), .Znc(Znc),
        .Zc_we(Zc_we), .Zc_addr(Zc_addr), .Zc_wdata(Zc_wdata),
        .ZG_we(ZG_we), .ZG_raddr(ZG_raddr), .ZG_caddr(ZG_caddr), .ZG_wdata(ZG_wdata),
        .ZA_we(ZA_we), .ZA_raddr(ZA_raddr), .ZA_caddr(ZA_caddr), .ZA_wdata(ZA_wdata),
        .Zb_we(Zb_we), .Zb_addr(Zb_addr), .Zb_wdata(Zb_wdata),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [1:0] k, input logic [7:0] r,
                                       input logic [7:0] c, input logic [31:0] d,
                                       input logic dn);
        return {13'd0, k, r, c, d, dn};
    endfunction

    // Write monitor: one record per strobe, sampled mid-cycle
    always @(negedge clk) begin
        nwe = int'(Zc_we) + int'(ZG_we) + int'(ZA_we) + int'(Zb_we);
        if (nwe > 1) multi++;
        if (done) dcnt++;
        if (Zc_we) log_q.push_back(pk(2'd0, 8'(Zc_addr), 8'd0, Zc_wdata, done));
        if (ZG_we) log_q.push_back(pk(2'd1, 8'(ZG_raddr), 8'(ZG_caddr), ZG_wdata, done));
        if (ZA_we) log_q.push_back(pk(2'd2, 8'(ZA_raddr), 8'(ZA_caddr), ZA_wdata, done));
        if (Zb_we) log_q.push_back(pk(2'd3, 8'(Zb_addr), 8'd0, Zb_wdata, done));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present one word and return at the negedge after it was accepted
    task automatic put(input logic [31:0] d, input logic l);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int k);
        s_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic add_rec(input int k, input int r, input int c, input int w,
                           input int tot, input int upto);
        if (w <= upto) exp_q.push_back(pk(2'(k), 8'(r), 8'(c), 32'(w), w == tot));
    endtask

    // Expected writes for words 1..upto of a frame with data words numbered from 1
    task automatic add_frame(input int n, input int ng, input int nc, input int upto);
        int w;
        int tot;
        w   = 1;
        tot = n + n * ng + nc * ng + nc;
        for (int r = 0; r < n; r++) begin add_rec(0, r, 0, w, tot, upto); w++; end
        for (int r = 0; r < n; r++)
            for (int g = 0; g < ng; g++) begin add_rec(1, r, g, w, tot, upto); w++; end
        for (int r = 0; r < nc; r++)
            for (int g = 0; g < ng; g++) begin add_rec(2, r, g, w, tot, upto); w++; end
        for (int r = 0; r < nc; r++) begin add_rec(3, r, 0, w, tot, upto); w++; end
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_nwr"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk({tag, "_wr"}, log_q[i], exp_q[i]);
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dims"}, 64'({Zn, Zng, Znc}), 64'd0);
        chk({tag, "_flags"}, 64'({busy, done, err, s_ready, Zc_we, ZG_we, ZA_we, Zb_we}), 64'd0);
        chk({tag, "_addr"}, 64'({Zc_addr, ZG_raddr, ZG_caddr, ZA_raddr, ZA_caddr, Zb_addr}), 64'd0);
        chk({tag, "_wdata"}, 64'(Zc_wdata | ZG_wdata | ZA_wdata | Zb_wdata), 64'd0);
    endtask

    task automatic chk_dims(input string tag, input int n, input int ng, input int nc);
        chk({tag, "_zn"},  64'(Zn),  64'(n));
        chk({tag, "_zng"}, 64'(Zng), 64'(ng));
        chk({tag, "_znc"}, 64'(Znc), 64'(nc));
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Full frame n=2 ng=3 nc=1, back-to-back
        put(32'h0001_0302, 1'b0);
        for (int w = 1; w <= 12; w++) put(32'(w), w == 12);
        idle(2);
        add_frame(2, 3, 1, 12);
        cmp_log("t1");
        chk_dims("t1", 2, 3, 1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_done_cnt", 64'(dcnt), 64'd1);

        // n=3 ng=2 nc=0, immediately followed by a stalled copy of the first frame
        put(32'h0000_0203, 1'b0);
        chk_dims("t2", 3, 2, 0);
        for (int w = 1; w <= 9; w++) put(32'(w), w == 9);
        put(32'h0001_0302, 1'b0);
        chk_dims("t3_hdr", 2, 3, 1);
        chk("t3_busy", 64'(busy), 64'd1);
        for (int w = 1; w <= 12; w++) begin
            idle(1);
            put(32'(w), w == 12);
        end
        idle(2);
        add_frame(3, 2, 0, 9);
        add_frame(2, 3, 1, 12);
        cmp_log("t23");
        chk("t23_done_cnt", 64'(dcnt), 64'd3);
        chk("t23_err", 64'(err), 64'd0);

        // Invalid header n=4 drained
        put(32'h0001_0304, 1'b0);
        chk("t4_busy", 64'(busy), 64'd1);
        for (int w = 1; w <= 5; w++) put(32'(w), w == 5);
        idle(2);
        cmp_log("t4");
        chk("t4_err", 64'(err), 64'd1);
        chk_dims("t4", 2, 3, 1);
        chk("t4_busy_end", 64'(busy), 64'd0);
        chk("t4_done_cnt", 64'(dcnt), 64'd3);

        // Premature s_last on word 5
        put(32'h0001_0302, 1'b0);
        chk("t5_err_clr", 64'(err), 64'd0);
        for (int w = 1; w <= 5; w++) put(32'(w), w == 5);
        idle(2);
        add_frame(2, 3, 1, 4);
        cmp_log("t5");
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done_cnt", 64'(dcnt), 64'd3);

        // Reset after word 6, then a fresh frame
        put(32'h0001_0302, 1'b0);
        for (int w = 1; w <= 6; w++) put(32'(w), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t6_rst");
        rst = 1'b0;
        put(32'h0001_0302, 1'b0);
        for (int w = 1; w <= 12; w++) put(32'(w), w == 12);
        idle(2);
        add_frame(2, 3, 1, 6);
        add_frame(2, 3, 1, 12);
        cmp_log("t6");
        chk_dims("t6", 2, 3, 1);
        chk("t6_err", 64'(err), 64'd0);
        chk("t6_done_cnt", 64'(dcnt), 64'd4);

        chk("one_hot_we", 64'(multi), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
